ramp_conversion_sequencer: RTL

- Sequences one single-slope (ramp) ADC conversion per request.
- Generates the ramp counter and ramp reset/enable strobes, synchronises the comparator, and captures the code at the first comparator rising edge.
- Delivers the result on a valid/ready interface.
- Sits between the analog ramp/comparator front end and downstream sampling/readout logic; it owns the `counter` bus that samplers observe.

---
 rtl/ramp_seq_pkg.sv | 23 ++
 rtl/comp_edge_sync.sv | 29 ++
 rtl/ramp_conversion_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ramp_seq_pkg.sv
// Shared types and constants for the ramp conversion sequencer and its comparator sampler.
package ramp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    RAMP   = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } seq_state_t;

  localparam int DRAIN_CYCLES = 32'd2;
  localparam int SYNC_STAGES  = 32'd2;

  function automatic int timer_width(input int cycles);
    return (cycles <= 32'd1) ? 32'd1 : $clog2(cycles);
  endfunction

  function automatic int acc_width(input int width, input int avg_log2);
    return width + avg_log2;
  endfunction

endpackage

// File: rtl/comp_edge_sync.sv
// Multi-flop synchroniser followed by a rising-edge detector; clr restarts edge detection
// so a level that is already high counts as a fresh edge.
module comp_edge_sync
  import ramp_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchroniser shift chain and previous-value flop of the edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      prev_r <= clr ? 1'b0 : sync_r[SYNC_STAGES-1];
    end
  end

  assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/ramp_conversion_sequencer.sv
// Single-slope ADC conversion sequencer: settle, ramp, capture at comparator crossing, hand off.
// Optional multi-pass averaging is enabled by defining RAMP_SEQ_AVG_EN.
module ramp_conversion_sequencer
  import ramp_seq_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int AVG_LOG2      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             comp,
  output logic [WIDTH-1:0] counter,
  output logic             ramp_rst,
  output logic             ramp_en,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overflow
);

  localparam int               TW         = timer_width(SETTLE_CYCLES);
  localparam logic [TW-1:0]    TIMER_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       DRAIN_LAST = 2'(DRAIN_CYCLES - 1);
  localparam logic [WIDTH-1:0] CODE_MAX   = {WIDTH{1'b1}};

  seq_state_t       state_r, next_s;
  logic [TW-1:0]    timer_r;
  logic [1:0]       drain_r;
  logic [WIDTH-1:0] cnt_d1_r, cnt_d2_r;
  logic             rise_s, enter_ramp_s, cap_s, last_pass_s;
  logic [WIDTH-1:0] code_s;

  comp_edge_sync u_comp_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (enter_ramp_s),
    .d    (comp),
    .rise (rise_s)
  );

  // Next-state selection
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:   if (start) next_s = SETTLE; else next_s = IDLE;
      SETTLE: if (timer_r == {TW{1'b0}}) next_s = RAMP; else next_s = SETTLE;
      RAMP: begin
        if (rise_s)                 next_s = DRAIN;
        else if (counter == CODE_MAX) next_s = last_pass_s ? DONE : SETTLE;
        else                        next_s = RAMP;
      end
      DRAIN:  if (drain_r == DRAIN_LAST) next_s = last_pass_s ? DONE : SETTLE; else next_s = DRAIN;
      DONE: begin
        if (result_valid && result_ready) next_s = continuous ? SETTLE : IDLE;
        else                              next_s = DONE;
      end
      default: next_s = IDLE;
    endcase
  end

  assign enter_ramp_s = (state_r == SETTLE) && (next_s == RAMP);
  assign cap_s        = (state_r == RAMP) && (rise_s || (counter == CODE_MAX));
  // A crossing reports the code seen when the first sync flop sampled it
  assign code_s       = rise_s ? cnt_d2_r : CODE_MAX;

  // State register and registered front-end strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      ramp_rst     <= 1'b1;
      ramp_en      <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state_r      <= next_s;
      ramp_rst     <= (next_s == IDLE) || (next_s == SETTLE) || (next_s == DONE);
      ramp_en      <= (next_s == RAMP);
      busy         <= (next_s != IDLE);
      result_valid <= (next_s == DONE);
    end
  end

  // Settle and drain timers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= {TW{1'b0}};
      drain_r <= 2'd0;
    end else begin
      if ((next_s == SETTLE) && (state_r != SETTLE)) timer_r <= TIMER_LOAD;
      else if ((state_r == SETTLE) && (timer_r != {TW{1'b0}})) timer_r <= timer_r - TW'(1);
      drain_r <= (state_r == DRAIN) ? drain_r + 2'd1 : 2'd0;
    end
  end

  // Ramp counter and its latency-matching delay line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter  <= {WIDTH{1'b0}};
      cnt_d1_r <= {WIDTH{1'b0}};
      cnt_d2_r <= {WIDTH{1'b0}};
    end else begin
      if (next_s == SETTLE) counter <= {WIDTH{1'b0}};
      else if ((state_r == RAMP) && (next_s == RAMP)) counter <= counter + WIDTH'(1);
      if (state_r == SETTLE) begin
        cnt_d1_r <= {WIDTH{1'b0}};
        cnt_d2_r <= {WIDTH{1'b0}};
      end else begin
        cnt_d1_r <= counter;
        cnt_d2_r <= cnt_d1_r;
      end
    end
  end

`ifdef RAMP_SEQ_AVG_EN
  localparam int ACC_W = acc_width(WIDTH, AVG_LOG2);

  logic [AVG_LOG2-1:0] pass_r;
  logic [ACC_W-1:0]    acc_r, acc_sum_s;
  logic                ovf_acc_r;

  assign last_pass_s = &pass_r;
  assign acc_sum_s   = acc_r + ACC_W'(code_s);

  // Pass counting, accumulation and final averaged result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_r    <= {AVG_LOG2{1'b0}};
      acc_r     <= {ACC_W{1'b0}};
      ovf_acc_r <= 1'b0;
      result    <= {WIDTH{1'b0}};
      overflow  <= 1'b0;
    end else begin
      if (((state_r == IDLE) || (state_r == DONE)) && (next_s == SETTLE)) begin
        pass_r    <= {AVG_LOG2{1'b0}};
        acc_r     <= {ACC_W{1'b0}};
        ovf_acc_r <= 1'b0;
      end else if (next_s == SETTLE) begin
        pass_r <= pass_r + AVG_LOG2'(1);
      end
      if (cap_s) begin
        acc_r     <= acc_sum_s;
        ovf_acc_r <= ovf_acc_r | ~rise_s;
        if (last_pass_s) begin
          result   <= WIDTH'(acc_sum_s >> AVG_LOG2);
          overflow <= ovf_acc_r | ~rise_s;
        end
      end
    end
  end
`else
  logic unused_avg_s;

  assign last_pass_s  = 1'b1;
  assign unused_avg_s = (AVG_LOG2 != 32'd0);

  // Single-pass result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= {WIDTH{1'b0}};
      overflow <= 1'b0;
    end else if (cap_s) begin
      result   <= code_s;
      overflow <= ~rise_s;
    end
  end
`endif

endmodule
